// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_decode_stage_if : IF/ID -> ID/EX handshake bundle for imm_decode_stage |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface imm_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport master (
        output in_valid, inst, pc, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

    modport slave (
        input  in_valid, inst, pc, flush, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_decode_stage : registered RV32I/RV64I immediate + PC-relative target   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    imm_decode_stage_if.slave bus
);
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_reg    = 7'b0110011;

    localparam logic [2:0] c_fmt_r   = 3'd0;
    localparam logic [2:0] c_fmt_i   = 3'd1;
    localparam logic [2:0] c_fmt_s   = 3'd2;
    localparam logic [2:0] c_fmt_b   = 3'd3;
    localparam logic [2:0] c_fmt_u   = 3'd4;
    localparam logic [2:0] c_fmt_j   = 3'd5;
    localparam logic [2:0] c_fmt_bad = 3'd7;

    localparam logic [XLEN-1:0] c_pc_step = {{(XLEN-3){1'b0}}, 3'b100};

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [31:0]     w_imm32;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic            w_pc_rel;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic            w_accept;

    logic            valid_q;
    logic            valid_d;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] target_q;
    logic [2:0]      fmt_q;
    logic            illegal_q;

    assign w_opcode = bus.inst[6:0];
    assign w_funct3 = bus.inst[14:12];

    // Every format is built as a 32-bit signed value first, then widened once.
    always_comb begin
        w_imm32   = 32'd0;
        w_fmt     = c_fmt_bad;
        w_illegal = 1'b0;
        w_pc_rel  = 1'b0;
        case (w_opcode)
            c_op_imm: begin
                w_fmt = c_fmt_i;
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    // shamt only; funct7 bits (arithmetic-shift select) are dropped
                    if (XLEN == 64) w_imm32 = {26'd0, bus.inst[25:20]};
                    else            w_imm32 = {27'd0, bus.inst[24:20]};
                end else begin
                    w_imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
                end
            end
            c_op_load, c_op_jalr, c_op_system: begin
                w_fmt   = c_fmt_i;
                w_imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
            end
            c_op_store: begin
                w_fmt   = c_fmt_s;
                w_imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
            end
            c_op_branch: begin
                w_fmt    = c_fmt_b;
                w_pc_rel = 1'b1;
                w_imm32  = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                            bus.inst[30:25], bus.inst[11:8], 1'b0};
            end
            c_op_lui: begin
                w_fmt   = c_fmt_u;
                w_imm32 = {bus.inst[31:12], 12'd0};
            end
            c_op_auipc: begin
                w_fmt    = c_fmt_u;
                w_pc_rel = 1'b1;
                w_imm32  = {bus.inst[31:12], 12'd0};
            end
            c_op_jal: begin
                w_fmt    = c_fmt_j;
                w_pc_rel = 1'b1;
                w_imm32  = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                            bus.inst[20], bus.inst[30:21], 1'b0};
            end
            c_op_reg: begin
                w_fmt = c_fmt_r;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    // JALR falls through to pc+4: its rs1-relative target is resolved in EX.
    assign w_target = bus.pc + (w_pc_rel ? w_imm : c_pc_step);

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d = valid_q;
        if (bus.flush)         valid_d = 1'b0;
        else if (w_accept)     valid_d = 1'b1;
        else if (bus.out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            imm_q     <= '0;
            target_q  <= '0;
            fmt_q     <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (w_accept) begin
                imm_q     <= w_imm;
                target_q  <= w_target;
                fmt_q     <= w_fmt;
                illegal_q <= w_illegal;
            end
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_target  = target_q;
    assign bus.out_fmt     = fmt_q;
    assign bus.out_illegal = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imm_decode_stage : scoreboard bench for imm_decode_stage (XLEN 32 & 64) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_imm_decode_stage;
    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   cyc;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[14];

    imm_decode_stage_if #(.XLEN(32)) ifc32 ();
    imm_decode_stage_if #(.XLEN(64)) ifc64 ();

    imm_decode_stage #(.XLEN(32)) u_dut32 (.clk(clk), .reset_n(reset_n), .bus(ifc32));
    imm_decode_stage #(.XLEN(64)) u_dut64 (.clk(clk), .reset_n(reset_n), .bus(ifc64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one instruction and hold it until accepted; the expectation is
    // queued at the accepting edge unless the entry is meant to be discarded.
    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] eimm,
                        input logic [2:0] efmt, input logic [31:0] etgt, input logic eill,
                        input bit push, input bit fl);
        int n;
        exp_t e;
        ifc32.inst     = i;
        ifc32.pc       = p;
        ifc32.in_valid = 1'b1;
        ifc32.flush    = fl;
        n = 0;
        @(negedge clk);
        while (!ifc32.in_ready && n < 20) begin
            n = n + 1;
            @(negedge clk);
        end
        if (!ifc32.in_ready) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL accept_timeout: in_ready stuck at 0 for inst %h", i);
        end else if (push) begin
            e.imm = eimm; e.fmt = efmt; e.tgt = etgt; e.ill = eill;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        ifc32.in_valid = 1'b0;
        ifc32.flush    = 1'b0;
    endtask

    task automatic send64(input string name, input logic [31:0] i, input logic [63:0] p,
                          input logic [63:0] eimm, input logic [2:0] efmt, input logic [63:0] etgt);
        ifc64.inst     = i;
        ifc64.pc       = p;
        ifc64.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc64.in_valid = 1'b0;
        chk({name, "_valid"}, {63'd0, ifc64.out_valid}, 64'd1);
        chk({name, "_imm"}, ifc64.out_imm, eimm);
        chk({name, "_fmt"}, {61'd0, ifc64.out_fmt}, {61'd0, efmt});
        chk({name, "_target"}, ifc64.out_target, etgt);
    endtask

    // Monitor: every consumed result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && ifc32.out_valid && ifc32.out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_err = n_err + 1;
                $display("FAIL unexpected_output: imm %h fmt %0d presented, required no output",
                         ifc32.out_imm, ifc32.out_fmt);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_imm",     {32'd0, ifc32.out_imm},     {32'd0, mon_e.imm});
                chk("sb_fmt",     {61'd0, ifc32.out_fmt},     {61'd0, mon_e.fmt});
                chk("sb_target",  {32'd0, ifc32.out_target},  {32'd0, mon_e.tgt});
                chk("sb_illegal", {63'd0, ifc32.out_illegal}, {63'd0, mon_e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //          inst          pc            imm           fmt   target        ill
        vecs[0]  = '{32'h4030D093, 32'h00000104, 32'h00000003, 3'd1, 32'h00000108, 1'b0}; // srai 3
        vecs[1]  = '{32'hFE000EE3, 32'h00000000, 32'hFFFFFFFC, 3'd3, 32'hFFFFFFFC, 1'b0}; // beq -4 wrap
        vecs[2]  = '{32'h123450B7, 32'h00000200, 32'h12345000, 3'd4, 32'h00000204, 1'b0}; // lui
        vecs[3]  = '{32'h0000007F, 32'h00000300, 32'h00000000, 3'd7, 32'h00000304, 1'b1}; // illegal
        vecs[4]  = '{32'h0020A423, 32'h00000310, 32'h00000008, 3'd2, 32'h00000314, 1'b0}; // sw +8
        vecs[5]  = '{32'hFE20AE23, 32'h00000314, 32'hFFFFFFFC, 3'd2, 32'h00000318, 1'b0}; // sw -4
        vecs[6]  = '{32'h008000EF, 32'h00000400, 32'h00000008, 3'd5, 32'h00000408, 1'b0}; // jal +8
        vecs[7]  = '{32'hFF9FF0EF, 32'h00000010, 32'hFFFFFFF8, 3'd5, 32'h00000008, 1'b0}; // jal -8
        vecs[8]  = '{32'h00001097, 32'h00001000, 32'h00001000, 3'd4, 32'h00002000, 1'b0}; // auipc
        vecs[9]  = '{32'h00008067, 32'h00000020, 32'h00000000, 3'd1, 32'h00000024, 1'b0}; // jalr
        vecs[10] = '{32'h002081B3, 32'h00000030, 32'h00000000, 3'd0, 32'h00000034, 1'b0}; // add
        vecs[11] = '{32'h01F09093, 32'h00000040, 32'h0000001F, 3'd1, 32'h00000044, 1'b0}; // slli 31
        vecs[12] = '{32'h43F0D093, 32'h00000044, 32'h0000001F, 3'd1, 32'h00000048, 1'b0}; // srai, 5-bit shamt
        vecs[13] = '{32'h008000EF, 32'hFFFFFFFC, 32'h00000008, 3'd5, 32'h00000004, 1'b0}; // jal wrap

        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        ifc32.in_valid = 1'b0; ifc32.inst = 32'd0; ifc32.pc = 32'd0;
        ifc32.flush = 1'b0;    ifc32.out_ready = 1'b1;
        ifc64.in_valid = 1'b0; ifc64.inst = 32'd0; ifc64.pc = 64'd0;
        ifc64.flush = 1'b0;    ifc64.out_ready = 1'b1;

        #3;
        chk("rst_valid",   {63'd0, ifc32.out_valid},   64'd0);
        chk("rst_imm",     {32'd0, ifc32.out_imm},     64'd0);
        chk("rst_fmt",     {61'd0, ifc32.out_fmt},     64'd0);
        chk("rst_target",  {32'd0, ifc32.out_target},  64'd0);
        chk("rst_illegal", {63'd0, ifc32.out_illegal}, 64'd0);
        chk("rst_in_ready",{63'd0, ifc32.in_ready},    64'd1);
        #9;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        send64("x64_lui",  32'h800000B7, 64'h0, 64'hFFFFFFFF80000000, 3'd4, 64'h4);
        send64("x64_srai", 32'h43F0D093, 64'h8, 64'h000000000000003F, 3'd1, 64'hC);
        send64("x64_beq",  32'hFE000EE3, 64'h0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC);
        send64("x64_addi", 32'hFFF00093, 64'h100, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h104);

        // Single addi: one-cycle latency, then out_valid drops when idle.
        send(32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 32'h104, 1'b0, 1'b1, 1'b0);
        chk("latency_valid", {63'd0, ifc32.out_valid}, 64'd1);
        @(posedge clk);
        #1;
        chk("idle_drop_valid", {63'd0, ifc32.out_valid}, 64'd0);

        // Back-to-back stream must sustain one transfer per cycle.
        begin
            int c0;
            c0 = cyc;
            for (int k = 0; k < 14; k++)
                send(vecs[k].inst, vecs[k].pc, vecs[k].imm, vecs[k].fmt, vecs[k].tgt,
                     vecs[k].ill, 1'b1, 1'b0);
            chk("throughput_cycles", 64'(cyc - c0), 64'd14);
        end
        @(posedge clk);
        #1;

        // Back-pressure: first result holds, second waits, no loss or duplication.
        ifc32.out_ready = 1'b0;
        send(32'h123450B7, 32'h500, 32'h12345000, 3'd4, 32'h504, 1'b0, 1'b1, 1'b0);
        ifc32.inst = 32'hFFF00093; ifc32.pc = 32'h504; ifc32.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready",  {63'd0, ifc32.in_ready},   64'd0);
            chk("bp_valid",     {63'd0, ifc32.out_valid},  64'd1);
            chk("bp_hold_imm",  {32'd0, ifc32.out_imm},    64'h12345000);
            chk("bp_hold_fmt",  {61'd0, ifc32.out_fmt},    64'd4);
            chk("bp_hold_tgt",  {32'd0, ifc32.out_target}, 64'h504);
            @(posedge clk);
            #1;
        end
        ifc32.out_ready = 1'b1;
        send(32'hFFF00093, 32'h504, 32'hFFFFFFFF, 3'd1, 32'h508, 1'b0, 1'b1, 1'b0);
        chk("bp_second_valid", {63'd0, ifc32.out_valid}, 64'd1);
        @(posedge clk);
        #1;
        chk("bp_drain_valid", {63'd0, ifc32.out_valid}, 64'd0);

        // Flush while a result is valid and a new entry is accepted.
        send(32'h008000EF, 32'h600, 32'h00000008, 3'd5, 32'h608, 1'b0, 1'b1, 1'b0);
        send(32'h123450B7, 32'h700, 32'h12345000, 3'd4, 32'h704, 1'b0, 1'b0, 1'b1);
        chk("flush_valid", {63'd0, ifc32.out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("flush_stays_low", {63'd0, ifc32.out_valid}, 64'd0);

        // Asynchronous reset mid-cycle drops a held result without a clock edge.
        ifc32.out_ready = 1'b0;
        send(32'h002081B3, 32'h800, 32'h0, 3'd0, 32'h804, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", {63'd0, ifc32.out_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid",    {63'd0, ifc32.out_valid},  64'd0);
        chk("async_rst_in_ready", {63'd0, ifc32.in_ready},   64'd1);
        chk("async_rst_target",   {32'd0, ifc32.out_target}, 64'd0);
        #2;
        reset_n = 1'b1;
        ifc32.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
